int_partial_sum_accumulator: RTL and testbench

// - Sink-side companion to int_adder_tree: accepts a stream of signed/unsigned partial sums, one per beat.
// - Accumulates NUM_BEATS partial sums, or fewer if data_in_last ends a group early, into one wide result.
// - Emits the result on a valid/ready output; performs the temporal reduction that follows the spatial tree reduction.

---
 rtl/int_partial_sum_accumulator.sv | 94 +++++++++
 tb/tb_int_partial_sum_accumulator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/int_partial_sum_accumulator.sv
// Temporal reduction stage after int_adder_tree: sums up to NUM_BEATS
// partial sums per group and emits one wide result on a valid/ready port.
module int_partial_sum_accumulator #(
  parameter int IN_BITS   = 10,
  parameter int OUT_BITS  = 16,
  parameter int NUM_BEATS = 4,
  parameter bit SIGN_EXT  = 1'b1,
  localparam int CNT_W    = $clog2(NUM_BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_BITS-1:0]  data_in,
  input  logic                data_in_valid,
  input  logic                data_in_last,
  output logic                data_in_ready,
  output logic [OUT_BITS-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic [CNT_W-1:0]    beat_count
);

  generate
    if (NUM_BEATS < 1) begin : g_bad_beats
      $error("NUM_BEATS must be >= 1");
    end
    if (OUT_BITS < IN_BITS + $clog2(NUM_BEATS)) begin : g_bad_width
      $error("OUT_BITS too narrow for NUM_BEATS sums");
    end
  endgenerate

  // Group state lives in the beat counter: zero means no open group.
  localparam logic [CNT_W-1:0] CNT_EMPTY = '0;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_BEATS - 1);

  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic [OUT_BITS-1:0] out_q, out_d;
  logic                vld_q, vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OUT_BITS-1:0] ext;
  logic [OUT_BITS-1:0] sum;
  logic                accept_in;
  logic                accept_out;
  logic                is_final;

  assign data_in_ready  = !vld_q || data_out_ready;
  assign data_out       = out_q;
  assign data_out_valid = vld_q;
  assign beat_count     = cnt_q;

  always_comb begin
    ext = SIGN_EXT ? OUT_BITS'(signed'(data_in))
                   : OUT_BITS'(data_in);
    sum = (cnt_q == CNT_EMPTY) ? ext : acc_q + ext;
    accept_in  = data_in_valid && data_in_ready;
    accept_out = vld_q && data_out_ready;
    is_final   = accept_in &&
                 (data_in_last || cnt_q == CNT_LAST);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    vld_d = vld_q;
    if (accept_out) begin
      vld_d = 1'b0;
    end
    // A final beat in the same cycle as a drain refills with no bubble.
    if (is_final) begin
      out_d = sum;
      vld_d = 1'b1;
      cnt_d = CNT_EMPTY;
    end else if (accept_in) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: tb/tb_int_partial_sum_accumulator.sv
// Bench: three configurations driven in lockstep, each checked against
// an arithmetic group-sum model every cycle.
module tb_int_partial_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  din = '0;
  logic        dv = 1'b0;
  logic        dl = 1'b0;
  logic        ordy = 1'b0;

  logic        rdy[3];
  logic [15:0] dout[3];
  logic        dval[3];
  logic [2:0]  bc[3];
  logic [2:0]  bc0, bc1;
  logic [0:0]  bc2;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance
  int          nb[3] = '{4, 4, 1};
  bit          se[3] = '{1'b1, 1'b0, 1'b1};
  longint      msum[3];
  int          mcnt[3];
  bit          mval[3];
  logic [15:0] mout[3];

  always #5 clk = ~clk;

  int_partial_sum_accumulator #(
    .IN_BITS(10), .OUT_BITS(16), .NUM_BEATS(4), .SIGN_EXT(1'b1)
  ) u0 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(dv),
    .data_in_last(dl), .data_in_ready(rdy[0]), .data_out(dout[0]),
    .data_out_valid(dval[0]), .data_out_ready(ordy), .beat_count(bc0)
  );

  int_partial_sum_accumulator #(
    .IN_BITS(10), .OUT_BITS(16), .NUM_BEATS(4), .SIGN_EXT(1'b0)
  ) u1 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(dv),
    .data_in_last(dl), .data_in_ready(rdy[1]), .data_out(dout[1]),
    .data_out_valid(dval[1]), .data_out_ready(ordy), .beat_count(bc1)
  );

  int_partial_sum_accumulator #(
    .IN_BITS(10), .OUT_BITS(16), .NUM_BEATS(1), .SIGN_EXT(1'b1)
  ) u2 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(dv),
    .data_in_last(dl), .data_in_ready(rdy[2]), .data_out(dout[2]),
    .data_out_valid(dval[2]), .data_out_ready(ordy), .beat_count(bc2)
  );

  assign bc[0] = bc0;
  assign bc[1] = bc1;
  assign bc[2] = {2'b00, bc2};

  task automatic chk(input string tag, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] got %0h exp %0h", tag, k, got, exp);
    end
  endtask

  function automatic longint ext(input int k, input logic [9:0] d);
    if (se[k] && d[9]) return longint'(d) - 1024;
    return longint'(d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
      mval[k] = 1'b0;
      mout[k] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dv = 1'b0;
    dl = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 32'(dval[k]), 32'(0));
      chk("rst_out", k, 32'(dout[k]), 32'(0));
      chk("rst_count", k, 32'(bc[k]), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [9:0] d,
                     input logic l, input logic r);
    bit er;
    bit ai;
    @(negedge clk);
    dv = v;
    din = d;
    dl = l;
    ordy = r;
    #1;
    for (int k = 0; k < 3; k++) begin
      er = !mval[k] || r;
      chk("in_ready", k, 32'(rdy[k]), 32'(er));
      ai = v && er;
      if (mval[k] && r) mval[k] = 1'b0;
      if (ai) begin
        msum[k] = (mcnt[k] == 0) ? ext(k, d) : msum[k] + ext(k, d);
        mcnt[k]++;
        if (l || mcnt[k] == nb[k]) begin
          mout[k] = msum[k][15:0];
          mval[k] = 1'b1;
          mcnt[k] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 32'(dval[k]), 32'(mval[k]));
      chk("out_data", k, 32'(dout[k]), 32'(mout[k]));
      chk("beat_count", k, 32'(bc[k]), 32'(mcnt[k]));
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Signed group: 5, -3, 100, -512 -> -410
    cyc(1, 10'd5, 0, 1);
    cyc(1, 10'h3FD, 0, 1);
    cyc(1, 10'd100, 0, 1);
    cyc(1, 10'h200, 0, 1);
    chk("signed_sum", 0, 32'(dout[0]), 32'h0000_FE66);
    cyc(0, 10'd0, 0, 1);

    // Unsigned group of maxima
    repeat (4) cyc(1, 10'h3FF, 0, 1);
    chk("unsigned_sum", 1, 32'(dout[1]), 32'h0000_0FFC);
    cyc(0, 10'd0, 0, 1);

    // Early close, then a fresh full group
    cyc(1, 10'd7, 0, 1);
    cyc(1, 10'd9, 1, 1);
    chk("early_last", 0, 32'(dout[0]), 32'd16);
    repeat (4) cyc(1, 10'd1, 0, 1);
    chk("restart", 0, 32'(dout[0]), 32'd4);

    // Backpressure: pending result stalls all beats
    repeat (3) cyc(1, 10'd2, 0, 1);
    cyc(1, 10'd3, 1, 1);
    repeat (5) cyc(1, 10'd50, 0, 0);
    chk("held_out", 0, 32'(dout[0]), 32'd9);
    cyc(1, 10'd11, 1, 1);
    chk("no_bubble_v", 0, 32'(dval[0]), 32'd1);
    chk("no_bubble_d", 0, 32'(dout[0]), 32'd11);
    cyc(0, 10'd0, 0, 1);

    // Reset mid-group discards the partial sum
    cyc(1, 10'd6, 0, 1);
    cyc(1, 10'd6, 0, 1);
    do_reset();
    repeat (4) cyc(1, 10'd1, 0, 1);
    chk("post_reset", 0, 32'(dout[0]), 32'd4);

    // Single-beat config streams with no bubbles
    cyc(1, 10'd3, 0, 1);
    chk("nb1_a", 2, 32'(dout[2]), 32'd3);
    cyc(1, 10'h3FC, 0, 1);
    chk("nb1_b", 2, 32'(dout[2]), 32'h0000_FFFC);
    cyc(1, 10'd8, 0, 1);
    chk("nb1_c", 2, 32'(dout[2]), 32'd8);

    // Randomized traffic with backpressure and occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc(($urandom_range(0, 3) != 0), 10'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
